// File: rtl/res_packer.sv
// res_packer: collects the adder result stream, packs bytes LSB-first into
// 32-bit words, tracks per-packet byte count and 16-bit checksum, and
// buffers packed words in a small FIFO for the software-side drain.
module res_packer #(
    parameter int unsigned PKT_BYTES  = 512,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  res_i,
    input  logic        res_vld_i,
    input  logic        word_rdy_i,
    output logic [31:0] word_o,
    output logic        word_vld_o,
    output logic        pkt_done_o,
    output logic [15:0] pkt_sum_o,
    output logic [15:0] byte_cnt_o,
    output logic        overflow_o
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_IDX = 16'(PKT_BYTES - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]   pack_q, pack_d;
    logic [15:0]   run_sum_q, run_sum_d;
    logic [15:0]   pkt_sum_q, pkt_sum_d;
    logic          pkt_done_q, pkt_done_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic [1:0]    lane;
    logic [15:0]   sum_inc;
    logic          is_last;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;

    // Byte acceptance: lane write, counting, checksum and packet completion
    always_comb begin
        lane       = byte_cnt_q[1:0];
        sum_inc    = run_sum_q + {8'd0, res_i};
        is_last    = res_vld_i && (byte_cnt_q == LAST_IDX);
        push       = res_vld_i && (lane == 2'd3);
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        run_sum_d  = run_sum_q;
        pkt_sum_d  = pkt_sum_q;
        pkt_done_d = 1'b0;
        if (res_vld_i) begin
            pack_d[{lane, 3'b000} +: 8] = res_i;
            if (is_last) begin
                byte_cnt_d = '0;
                run_sum_d  = '0;
                pkt_sum_d  = sum_inc;
                pkt_done_d = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 16'd1;
                run_sum_d  = sum_inc;
            end
        end
    end

    // Packet FSM: opens on the first valid byte, closes on the last one
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (res_vld_i) state_d = ST_COLLECT;
            ST_COLLECT: if (is_last)   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FIFO control; a push into a full FIFO still succeeds if the head pops
    always_comb begin
        full       = (count_q == FULL_CNT);
        pop        = word_rdy_i && (count_q != '0);
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q || (push && full && !pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            run_sum_q  <= '0;
            pkt_sum_q  <= '0;
            pkt_done_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            run_sum_q  <= run_sum_d;
            pkt_sum_q  <= pkt_sum_d;
            pkt_done_q <= pkt_done_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are masked by the empty flag, so no reset needed
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= pack_d;
    end

    assign word_vld_o = (count_q != '0);
    assign word_o     = word_vld_o ? mem_q[rd_ptr_q] : '0;
    assign pkt_done_o = pkt_done_q;
    assign pkt_sum_o  = pkt_sum_q;
    assign byte_cnt_o = byte_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_res_packer.sv
// tb_res_packer: table-driven, directed and randomized checks of res_packer
// against a queue-based reference model.
module tb_res_packer;

    localparam int PKT   = 512;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  res_i;
    logic        res_vld_i;
    logic        word_rdy_i;
    logic [31:0] word_o;
    logic        word_vld_o;
    logic        pkt_done_o;
    logic [15:0] pkt_sum_o;
    logic [15:0] byte_cnt_o;
    logic        overflow_o;

    res_packer #(.PKT_BYTES(PKT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .res_i      (res_i),
        .res_vld_i  (res_vld_i),
        .word_rdy_i (word_rdy_i),
        .word_o     (word_o),
        .word_vld_o (word_vld_o),
        .pkt_done_o (pkt_done_o),
        .pkt_sum_o  (pkt_sum_o),
        .byte_cnt_o (byte_cnt_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc[$];
    int vld_seen = 0;

    // Reference model: FIFO as a queue, current group as a byte queue
    logic [31:0] m_q[$];
    logic [7:0]  m_grp[$];
    int          m_cnt, m_sum, m_psum;
    bit          m_done, m_ovf;

    typedef struct {
        bit          vld;
        logic [7:0]  res;
        bit          rdy;
        bit          e_vld;
        logic [31:0] e_word;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_grp.delete();
        m_cnt = 0; m_sum = 0; m_psum = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit vld, input logic [7:0] res, input bit rdy);
        logic [31:0] w;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        m_done = 0;
        if (vld) begin
            m_grp.push_back(res);
            m_cnt++;
            m_sum = (m_sum + int'(res)) % 65536;
            if (m_grp.size() == 4) begin
                w = {m_grp[3], m_grp[2], m_grp[1], m_grp[0]};
                m_grp.delete();
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
            if (m_cnt == PKT) begin
                m_psum = m_sum; m_sum = 0; m_cnt = 0; m_done = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("model word_vld", word_vld_o, m_q.size() > 0);
        chk("model word", word_o, (m_q.size() > 0) ? m_q[0] : 32'd0);
        chk("model pkt_done", pkt_done_o, m_done);
        chk("model pkt_sum", pkt_sum_o, m_psum);
        chk("model byte_cnt", byte_cnt_o, m_cnt);
        chk("model overflow", overflow_o, m_ovf);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " word"}, word_o, 0);
        chk({tag, " word_vld"}, word_vld_o, 0);
        chk({tag, " pkt_done"}, pkt_done_o, 0);
        chk({tag, " pkt_sum"}, pkt_sum_o, 0);
        chk({tag, " byte_cnt"}, byte_cnt_o, 0);
        chk({tag, " overflow"}, overflow_o, 0);
    endtask

    task automatic cycle(input bit vld, input logic [7:0] res, input bit rdy);
        res_vld_i  = vld;
        res_i      = res;
        word_rdy_i = rdy;
        model_step(vld, res, rdy);
        @(posedge clk_i);
        #1;
        cyc++;
        if (pkt_done_o) done_cyc.push_back(cyc);
        if (word_vld_o) vld_seen++;
        check_model();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        model_reset();
        #1;
        chk_all_zero("reset");
        @(posedge clk_i);
        #1;
        res_vld_i = 1'b0; res_i = '0; word_rdy_i = 1'b0;
        reset_i = 1'b0;
        done_cyc.delete();
        vld_seen = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;
        reset_i = 1'b1; res_vld_i = 1'b0; res_i = '0; word_rdy_i = 1'b0;
        model_reset();
        #1;
        chk_all_zero("power-on");
        do_reset();

        // Single word, table-driven
        tbl[0] = '{1, 8'h01, 1, 0, 32'h0,        16'd1};
        tbl[1] = '{1, 8'h02, 1, 0, 32'h0,        16'd2};
        tbl[2] = '{1, 8'h03, 1, 0, 32'h0,        16'd3};
        tbl[3] = '{1, 8'h04, 1, 1, 32'h04030201, 16'd4};
        tbl[4] = '{0, 8'h00, 1, 0, 32'h0,        16'd4};
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].vld, tbl[i].res, tbl[i].rdy);
            chk("tbl word_vld", word_vld_o, tbl[i].e_vld);
            chk("tbl word", word_o, tbl[i].e_word);
            chk("tbl byte_cnt", byte_cnt_o, tbl[i].e_cnt);
        end

        // Full packet of 0xFF
        do_reset();
        for (int i = 0; i < PKT; i++) cycle(1, 8'hFF, 1);
        chk("full pkt_done", pkt_done_o, 1);
        chk("full pkt_sum", pkt_sum_o, 32'hFE00);
        chk("full byte_cnt", byte_cnt_o, 0);
        chk("full word_count", vld_seen, 128);
        cycle(0, 8'h00, 1);
        chk("full pkt_done after", pkt_done_o, 0);
        chk("full done pulses", done_cyc.size(), 1);
        chk("full pkt_sum hold", pkt_sum_o, 32'hFE00);

        // Back-to-back packets
        do_reset();
        for (int i = 0; i < 2 * PKT; i++) begin
            cycle(1, 8'(i), 1);
            if (pkt_done_o) chk("b2b pkt_sum", pkt_sum_o, 32'hFF00);
        end
        cycle(0, 8'h00, 1);
        chk("b2b done pulses", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("b2b done spacing", done_cyc[1] - done_cyc[0], PKT);

        // Overflow: 17 words into a 16-deep FIFO, then drain in order
        do_reset();
        for (int k = 0; k < 68; k++) cycle(1, 8'(k), 0);
        chk("ovf overflow", overflow_o, 1);
        chk("ovf byte_cnt", byte_cnt_o, 68);
        for (int j = 0; j < DEPTH; j++) begin
            w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            chk("ovf drain word", word_o, w);
            chk("ovf drain vld", word_vld_o, 1);
            cycle(0, 8'h00, 1);
        end
        chk("ovf empty after drain", word_vld_o, 0);
        chk("ovf sticky", overflow_o, 1);

        // Push and pop on the same edge while full
        do_reset();
        for (int k = 0; k < 64; k++) cycle(1, 8'(k + 8'h40), 0);
        chk("pp full no ovf", overflow_o, 0);
        for (int k = 0; k < 3; k++) cycle(1, 8'h5A, 0);
        cycle(1, 8'h5A, 1);
        chk("pp no drop", overflow_o, 0);
        n = 0;
        while (word_vld_o && n < 40) begin
            cycle(0, 8'h00, 1);
            n++;
        end
        chk("pp occupancy", n, DEPTH);

        // Reset mid-packet
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1, 8'h11 + 8'(k), 0);
        reset_i = 1'b1;
        model_reset();
        #1;
        chk_all_zero("midpkt reset");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) cycle(1, 8'hAA, 0);
        chk("midpkt word", word_o, 32'hAAAAAAAA);
        chk("midpkt vld", word_vld_o, 1);
        chk("midpkt byte_cnt", byte_cnt_o, 4);

        // Randomized traffic with varying drain rate
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = int'($urandom_range(10, 90));
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 999) == 0) do_reset();
                cycle($urandom_range(0, 9) < 7, 8'($urandom),
                      int'($urandom_range(0, 99)) < rdy_pct);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_packer.md
# res_packer

Downstream collector for the adder result stream produced by the harness BFM. It consumes one 8-bit result per valid cycle and packs the results LSB-first into 32-bit words, matching the byte order in which the BFM unpacks its stimulus packet. It also keeps a per-packet byte count and a 16-bit checksum, and buffers packed words in a small FIFO for the software-side drain (DPI `recv`).

## Interface
- PKT_BYTES, 512, bytes per packet; must be a multiple of 4, ≥ 4, ≤ 65535.
- FIFO_DEPTH, 16, packed-word FIFO entries; power of two, ≥ 2.
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  reset, asynchronous, active-high.
- res_i  input  8  result byte from the adder.
- res_vld_i  input  1  res_i valid this cycle; no backpressure, every valid byte is accepted.
- word_rdy_i  input  1  drain ready; pops the FIFO head when word_vld_o is also high.
- word_o  output  32  FIFO head word; byte k of a group is at [8k+7:8k].
- word_vld_o  output  1  FIFO non-empty.
- pkt_done_o  output  1  one-cycle pulse after the last byte of a packet.
- pkt_sum_o  output  16  checksum of the most recently completed packet.
- byte_cnt_o  output  16  bytes accepted in the current packet.
- overflow_o  output  1  sticky; a packed word was dropped.

## Operation
- States:
  - IDLE: byte_cnt = 0, no packet open.
  - COLLECT: packet open.
- Transitions:
  - IDLE → COLLECT on res_vld_i.
  - COLLECT → IDLE on acceptance of byte PKT_BYTES-1; no further transitions.
- Accepted byte:
  - Written into lane byte_cnt[1:0] of a 32-bit pack register.
  - byte_cnt incremented.
  - run_sum = run_sum + res_i, modulo 2^16.
- Lane 3 written: the completed word (including the current byte) is pushed to the FIFO in the same edge.
- Last byte of a packet (byte_cnt == PKT_BYTES-1):
  - Word pushed.
  - byte_cnt → 0.
  - pkt_sum_o ← run_sum + res_i.
  - run_sum → 0.
  - pkt_done_o set for the next cycle.
- Back-to-back packets: a valid byte in the cycle after the last byte is byte 0 of the next packet. The FSM re-enters COLLECT with no bubble.
- FIFO:
  - Push when full and no pop in the same cycle: word dropped, overflow_o ← 1.
  - Push when full with a pop in the same cycle: succeeds, occupancy unchanged.
  - Pop when empty: ignored.
- Packet counting and checksum continue regardless of FIFO drops.
- overflow_o clears only on reset.

## Timing
- Reset values:
  - word_o = 0, word_vld_o = 0, pkt_done_o = 0, pkt_sum_o = 0, byte_cnt_o = 0, overflow_o = 0.
  - FIFO empty, pack register = 0, run_sum = 0, state IDLE.
- Reset mid-packet: all partial state is discarded immediately (asynchronous), and buffered FIFO words are lost. The first valid byte after reset release is byte 0.
- Latency: 4th byte of a group accepted at edge N with the FIFO empty → word_vld_o = 1 and word_o valid after edge N; the drain samples it at edge N+1.
- word_o is stable while word_vld_o = 1 and word_rdy_i = 0.
- pkt_done_o is high exactly in the cycle after the edge accepting the last byte. pkt_sum_o updates on that same edge and holds until the next packet completes.
- byte_cnt_o is registered and reflects the bytes accepted up to the previous edge.
- Full throughput: one byte per cycle sustained → one push per 4 cycles. This requires word_rdy_i at least 25% of cycles on average to avoid overflow.

## Test plan
- Single word: bytes 0x01, 0x02, 0x03, 0x04 on consecutive cycles, word_rdy_i = 1 → one word 0x04030201, word_vld_o high one cycle, byte_cnt_o = 4.
- Full packet: 512 bytes of 0xFF back-to-back → 128 words of 0xFFFFFFFF; pkt_done_o pulses once, the cycle after byte 512; pkt_sum_o = 0xFE00; byte_cnt_o returns to 0.
- Back-to-back packets: packet of bytes i & 0xFF (i = 0..511) followed immediately by the same packet → two pkt_done_o pulses 512 cycles apart; both pkt_sum_o = 0xFF00; no byte lost.
- Overflow: word_rdy_i = 0, 68 bytes → 16 words buffered, 17th dropped, overflow_o = 1. Then word_rdy_i = 1 → exactly 16 words drained in order, overflow_o stays 1.
- Full push/pop: FIFO full, word_rdy_i = 1 on the same cycle a 4th byte arrives → no drop, overflow_o = 0, occupancy stays 16.
- Reset mid-packet: assert reset_i after 6 bytes → all outputs 0 immediately. Then 4 bytes 0xAA after release → word 0xAAAAAAAA, byte_cnt_o = 4, no stale data.
